sync_fifo_v2: RTL and testbench

SYNC_FIFO_V2 -- requirements
Module: sync_fifo_v2

---
 rtl/sync_fifo_v2.sv | 71 +++++++
 tb/tb_sync_fifo_v2.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2: synchronous FIFO with count-decoded flags and sticky overflow/underflow.
// Define SYNC_FIFO_V2_SHOWAHEAD_EN for combinational show-ahead q; otherwise q is registered.
module sync_fifo_v2 #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] data,
    input  logic             wrreq,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [AW:0]      usedw,
    output logic             overflow,
    output logic             underflow
);
    localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_N   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_N   = (AW+1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             wr_en, rd_en;

    assign wr_en        = wrreq && !full && !clr;
    assign rd_en        = rdreq && !empty && !clr;
    assign empty        = usedw == '0;
    assign full         = usedw == FULL_N;
    assign almost_empty = usedw <= AE_N;
    assign almost_full  = usedw >= AF_N;

    always_ff @(posedge clk_in)
        if (wr_en) mem[wr_ptr] <= data;

    always_ff @(posedge clk_in or negedge rst_n)
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            usedw     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            usedw     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            if (wr_en != rd_en) usedw <= wr_en ? usedw + (AW+1)'(1) : usedw - (AW+1)'(1);
            if (wrreq && full) overflow <= 1'b1;
            if (rdreq && empty) underflow <= 1'b1;
        end

`ifdef SYNC_FIFO_V2_SHOWAHEAD_EN
    assign q = mem[rd_ptr];
`else
    always_ff @(posedge clk_in or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (rd_en) q <= mem[rd_ptr];
`endif
endmodule

// File: tb/tb_sync_fifo_v2.sv
// tb_sync_fifo_v2: randomized and directed checks of sync_fifo_v2 against a queue-based model.
module tb_sync_fifo_v2;
    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] data = '0;
    logic       wrreq = 1'b0;
    logic       rdreq = 1'b0;
    logic [7:0] q;
    logic       empty, full, almost_empty, almost_full, overflow, underflow;
    logic [4:0] usedw;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mq[$];
    logic [7:0] mqv;
    logic       movf, munf;

    sync_fifo_v2 dut (
        .clk_in(clk_in), .rst_n(rst_n), .clr(clr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .q(q), .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
        .usedw(usedw), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        movf = 1'b0;
        munf = 1'b0;
        mqv  = '0;
    endtask

    // Compare every output against the model; show-ahead q only matters when non-empty.
    task automatic check_all();
        int n = mq.size();
        chk("usedw", 32'(usedw), n);
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == 16));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
        chk("almost_full", 32'(almost_full), 32'(n >= 14));
        chk("overflow", 32'(overflow), 32'(movf));
        chk("underflow", 32'(underflow), 32'(munf));
`ifdef SYNC_FIFO_V2_SHOWAHEAD_EN
        if (n > 0) chk("q_head", 32'(q), 32'(mq[0]));
`else
        chk("q", 32'(q), 32'(mqv));
`endif
    endtask

    task automatic model_step(input logic w, input logic r, input logic c, input logic [7:0] d);
        bit was_full = mq.size() == 16;
        bit was_empty = mq.size() == 0;
        if (c) begin
            mq.delete();
            movf = 1'b0;
            munf = 1'b0;
        end else begin
            if (w && was_full) movf = 1'b1;
            if (r && was_empty) munf = 1'b1;
            if (r && !was_empty) mqv = mq.pop_front();
            if (w && !was_full) mq.push_back(d);
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic c, input logic [7:0] d);
        wrreq = w;
        rdreq = r;
        clr   = c;
        data  = d;
        @(posedge clk_in);
        model_step(w, r, c, d);
        @(negedge clk_in);
        wrreq = 1'b0;
        rdreq = 1'b0;
        clr   = 1'b0;
        check_all();
    endtask

    initial begin
        model_reset();
        #2;
        check_all();
        chk("rst_empty", 32'(empty), 1);
        chk("rst_usedw", 32'(usedw), 0);
        #10 rst_n = 1'b1;
        @(negedge clk_in);

        // Fill and drain
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 0, 8'(i));
            if (i == 12) chk("af_13", 32'(almost_full), 0);
            if (i == 13) chk("af_14", 32'(almost_full), 1);
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_usedw", 32'(usedw), 16);
        for (int i = 0; i < 16; i++) begin
`ifdef SYNC_FIFO_V2_SHOWAHEAD_EN
            chk("drain_head", 32'(q), i);
            cyc(0, 1, 0, 0);
`else
            cyc(0, 1, 0, 0);
            chk("drain_q", 32'(q), i);
`endif
        end
        chk("drain_empty", 32'(empty), 1);
        chk("drain_usedw", 32'(usedw), 0);

        // Wrap-around
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 8'(i + 8'h30));
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 8'(8'hA0 + i));
        for (int i = 0; i < 16; i++) begin
`ifdef SYNC_FIFO_V2_SHOWAHEAD_EN
            chk("wrap_head", 32'(q), 32'(8'hA0 + i));
            cyc(0, 1, 0, 0);
`else
            cyc(0, 1, 0, 0);
            chk("wrap_q", 32'(q), 32'(8'hA0 + i));
`endif
        end

        // Simultaneous access on full, then on empty
        for (int i = 0; i < 16; i++) cyc(1, 0, 0, 8'($urandom_range(0, 200)));
        cyc(1, 1, 0, 8'hEE);
        chk("sim_full_usedw", 32'(usedw), 15);
        chk("sim_full_ovf", 32'(overflow), 1);
        for (int i = 0; i < 15; i++) begin
            cyc(0, 1, 0, 0);
`ifndef SYNC_FIFO_V2_SHOWAHEAD_EN
            chk("no_dropped_word", 32'(q == 8'hEE), 0);
`endif
        end
        cyc(0, 0, 1, 0);
        cyc(1, 1, 0, 8'h11);
        chk("sim_empty_usedw", 32'(usedw), 1);
        chk("sim_empty_unf", 32'(underflow), 1);

        // clr with write, 7 words held
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 8'(i));
        chk("pre_clr_usedw", 32'(usedw), 7);
        cyc(1, 0, 1, 8'h77);
        chk("clr_usedw", 32'(usedw), 0);
        chk("clr_empty", 32'(empty), 1);
        chk("clr_unf", 32'(underflow), 0);
        chk("clr_ovf", 32'(overflow), 0);

        // Mid-operation asynchronous reset with 5 words held
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'(8'h60 + i));
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 8'h65);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("arst_usedw", 32'(usedw), 0);
        chk("arst_empty", 32'(empty), 1);
        #1 rst_n = 1'b1;
        @(negedge clk_in);
        cyc(1, 0, 0, 8'h55);
`ifdef SYNC_FIFO_V2_SHOWAHEAD_EN
        chk("after_rst_head", 32'(q), 32'h55);
`endif
        cyc(0, 1, 0, 0);
`ifndef SYNC_FIFO_V2_SHOWAHEAD_EN
        chk("after_rst_q", 32'(q), 32'h55);
`endif

        // Read latency of a single word
        cyc(1, 0, 0, 8'h3C);
`ifdef SYNC_FIFO_V2_SHOWAHEAD_EN
        chk("sa_3c_before_read", 32'(q), 32'h3C);
        cyc(0, 1, 0, 0);
`else
        wrreq = 1'b0;
        rdreq = 1'b1;
        @(posedge clk_in);
        #1;
        chk("q_3c_latency", 32'(q), 32'h3C);
        model_step(0, 1, 0, 0);
        @(negedge clk_in);
        rdreq = 1'b0;
        check_all();
`endif

        // Randomized traffic with shifting write/read bias
        for (int i = 0; i < 800; i++) begin
            int wp = (i / 100) % 2 == 0 ? 75 : 30;
            int rp = 100 - wp;
            cyc($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                $urandom_range(0, 249) == 0, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
